// File: rtl/instr_fetch_control_if.sv
// Instruction memory fetch handshake between the fetch controller and instruction memory.
interface instr_fetch_control_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemReady,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemReady,
        output imemData
    );
endinterface

// File: rtl/instr_fetch_control.sv
// Multi-cycle instruction fetch/decode controller: Moore FSM with registered outputs
// sequencing FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and counting retired instructions.
module instr_fetch_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    instr_fetch_control_if.master         imem,
    output logic [31:0]                   instruction,
    output logic                          RegDst,
    output logic                          MemRead,
    output logic                          MemtoReg,
    output logic                          MemWrite,
    output logic                          ALUSrc,
    output logic                          RegWrite,
    output logic [3:0]                    ALUCtrl,
    output logic                          illegalOp,
    output logic [31:0]                   retireCount
);

    typedef enum logic [2:0] {Fetch, Decode, Exec, Mem, Wb} state_e;
    typedef enum logic [2:0] {OpR, OpAddi, OpLw, OpSw, OpJ, OpIll} op_e;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        req_q, req_d;
    logic        reg_dst_q, reg_dst_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        mem_write_q, mem_write_d;
    logic        alu_src_q, alu_src_d;
    logic        reg_write_q, reg_write_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic        illegal_q, illegal_d;
    logic [31:0] retire_q, retire_d;

    op_e         dec_op;
    logic [3:0]  dec_alu;
    logic        dec_reg_dst;
    logic        dec_alu_src;
    logic        dec_mem_to_reg;

    // Instruction decode of the IR; unsupported encodings fall back to reset-value controls.
    always_comb begin
        dec_op         = OpIll;
        dec_alu        = AluAdd;
        dec_alu_src    = 1'b0;
        dec_mem_to_reg = 1'b0;
        unique case (ir_q[31:26])
            6'h00: begin
                dec_op = OpR;
                unique case (ir_q[5:0])
                    6'h20:   dec_alu = AluAdd;
                    6'h22:   dec_alu = AluSub;
                    6'h24:   dec_alu = AluAnd;
                    6'h25:   dec_alu = AluOr;
                    6'h27:   dec_alu = AluNor;
                    6'h2A:   dec_alu = AluSlt;
                    default: dec_op  = OpIll;
                endcase
            end
            6'h08: begin
                dec_op      = OpAddi;
                dec_alu_src = 1'b1;
            end
            6'h23: begin
                dec_op         = OpLw;
                dec_alu_src    = 1'b1;
                dec_mem_to_reg = 1'b1;
            end
            6'h2B: begin
                dec_op      = OpSw;
                dec_alu_src = 1'b1;
            end
            6'h02:   dec_op = OpJ;
            default: dec_op = OpIll;
        endcase
        dec_reg_dst = (dec_op == OpR);
    end

    // Next-state logic; outputs are registered from the next state so they align with it.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        reg_dst_d    = reg_dst_q;
        mem_to_reg_d = mem_to_reg_q;
        alu_src_d    = alu_src_q;
        alu_ctrl_d   = alu_ctrl_q;
        retire_d     = retire_q;
        illegal_d    = 1'b0;

        unique case (state_q)
            Fetch: begin
                // req_q gates imemReady so the cycle right after reset never accepts.
                if (req_q && imem.imemReady) begin
                    ir_d    = imem.imemData;
                    pc_d    = pc_q + 32'd4;
                    state_d = Decode;
                end
            end
            Decode: begin
                op_d         = dec_op;
                reg_dst_d    = dec_reg_dst;
                mem_to_reg_d = dec_mem_to_reg;
                alu_src_d    = dec_alu_src;
                alu_ctrl_d   = dec_alu;
                illegal_d    = (dec_op == OpIll);
                state_d      = Exec;
            end
            Exec: begin
                unique case (op_q)
                    OpJ: begin
                        pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
                        retire_d = retire_q + 32'd1;
                        state_d  = Fetch;
                    end
                    OpR, OpAddi: state_d = Wb;
                    OpLw, OpSw:  state_d = Mem;
                    default:     state_d = Fetch;
                endcase
            end
            Mem: begin
                if (op_q == OpLw) begin
                    state_d = Wb;
                end else begin
                    retire_d = retire_q + 32'd1;
                    state_d  = Fetch;
                end
            end
            Wb: begin
                retire_d = retire_q + 32'd1;
                state_d  = Fetch;
            end
            default: state_d = Fetch;
        endcase

        req_d       = (state_d == Fetch);
        mem_write_d = (state_d == Mem) && (op_q == OpSw);
        mem_read_d  = ((state_d == Mem) || (state_d == Wb)) && (op_q == OpLw);
        reg_write_d = (state_d == Wb);
    end

    // State and registered-output flops; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= Fetch;
            op_q         <= OpIll;
            pc_q         <= RESET_PC;
            ir_q         <= 32'h0;
            req_q        <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_ctrl_q   <= AluAdd;
            illegal_q    <= 1'b0;
            retire_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            req_q        <= req_d;
            reg_dst_q    <= reg_dst_d;
            mem_read_q   <= mem_read_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            alu_src_q    <= alu_src_d;
            reg_write_q  <= reg_write_d;
            alu_ctrl_q   <= alu_ctrl_d;
            illegal_q    <= illegal_d;
            retire_q     <= retire_d;
        end
    end

    assign imem.imemReq  = req_q;
    assign imem.imemAddr = pc_q;
    assign instruction   = ir_q;
    assign RegDst        = reg_dst_q;
    assign MemRead       = mem_read_q;
    assign MemtoReg      = mem_to_reg_q;
    assign MemWrite      = mem_write_q;
    assign ALUSrc        = alu_src_q;
    assign RegWrite      = reg_write_q;
    assign ALUCtrl       = alu_ctrl_q;
    assign illegalOp     = illegal_q;
    assign retireCount   = retire_q;

endmodule

// File: tb/tb_instr_fetch_control.sv
// Directed vector bench for instr_fetch_control: per-cycle table plus ALU and reset-abort sequences.
module tb_instr_fetch_control;

    localparam logic [31:0] ADD  = 32'h0022_1820;
    localparam logic [31:0] LW   = 32'h8C02_0008;
    localparam logic [31:0] SW   = 32'hAC02_0004;
    localparam logic [31:0] JMP  = 32'h0800_0040;
    localparam logic [31:0] ILL  = 32'hFC00_0000;
    localparam logic [31:0] ILLF = 32'h0000_0001;
    localparam logic [31:0] ADDI = 32'h2001_0005;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    instr_fetch_control_if if0 ();
    instr_fetch_control_if if1 ();

    logic [31:0] instr0, instr1, retire0, retire1;
    logic        rd0, mr0, m2r0, mw0, as0, rw0, ill0;
    logic        rd1, mr1, m2r1, mw1, as1, rw1, ill1;
    logic [3:0]  alu0, alu1;

    instr_fetch_control #(.RESET_PC(32'h0000_0000)) u_dut0 (
        .clk(clk), .reset(rst0), .imem(if0.master), .instruction(instr0),
        .RegDst(rd0), .MemRead(mr0), .MemtoReg(m2r0), .MemWrite(mw0), .ALUSrc(as0),
        .RegWrite(rw0), .ALUCtrl(alu0), .illegalOp(ill0), .retireCount(retire0)
    );

    instr_fetch_control #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
        .clk(clk), .reset(rst1), .imem(if1.master), .instruction(instr1),
        .RegDst(rd1), .MemRead(mr1), .MemtoReg(m2r1), .MemWrite(mw1), .ALUSrc(as1),
        .RegWrite(rw1), .ALUCtrl(alu1), .illegalOp(ill1), .retireCount(retire1)
    );

    // {req, addr, ir, rd, mr, m2r, mw, as, rw, alu, ill, retire}
    typedef logic [107:0] obs_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] data;
        obs_t        exp;
    } vec_t;

    vec_t vecs[$];
    int   applied = 0;
    int   miscompares = 0;

    function automatic obs_t pack0();
        return {if0.imemReq, if0.imemAddr, instr0, rd0, mr0, m2r0, mw0, as0, rw0, alu0, ill0,
                retire0};
    endfunction

    function automatic obs_t pack1();
        return {if1.imemReq, if1.imemAddr, instr1, rd1, mr1, m2r1, mw1, as1, rw1, alu1, ill1,
                retire1};
    endfunction

    function automatic obs_t mk(input logic req, input logic [31:0] addr, input logic [31:0] ir,
                                input logic [5:0] ctl, input logic [3:0] alu, input logic ill,
                                input logic [31:0] rc);
        return {req, addr, ir, ctl, alu, ill, rc};
    endfunction

    // ctl bits: RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite
    function automatic void add(input logic rst, input logic rdy, input logic [31:0] data,
                                input logic req, input logic [31:0] addr, input logic [31:0] ir,
                                input logic [5:0] ctl, input logic ill, input logic [31:0] rc);
        vec_t v;
        v.rst  = rst;
        v.rdy  = rdy;
        v.data = data;
        v.exp  = mk(req, addr, ir, ctl, 4'b0010, ill, rc);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [5:0] functs[6];
        logic [3:0] alus[6];

        rst1 = 1'b1;
        if1.imemReady = 1'b0;
        if1.imemData  = 32'h0;

        // Reset and add
        add(1, 0, ADD,  0, 32'h000, 32'h0, 6'b000000, 0, 0);
        add(0, 1, ADD,  1, 32'h000, 32'h0, 6'b000000, 0, 0);
        add(0, 1, ADD,  0, 32'h004, ADD,   6'b000000, 0, 0);
        add(0, 1, ADD,  0, 32'h004, ADD,   6'b100000, 0, 0);
        add(0, 1, ADD,  0, 32'h004, ADD,   6'b100001, 0, 0);
        add(0, 1, LW,   1, 32'h004, ADD,   6'b100000, 0, 1);
        // lw
        add(0, 1, LW,   0, 32'h008, LW,    6'b100000, 0, 1);
        add(0, 1, LW,   0, 32'h008, LW,    6'b001010, 0, 1);
        add(0, 1, LW,   0, 32'h008, LW,    6'b011010, 0, 1);
        add(0, 1, LW,   0, 32'h008, LW,    6'b011011, 0, 1);
        add(0, 1, SW,   1, 32'h008, LW,    6'b001010, 0, 2);
        // sw after three wait cycles
        add(0, 0, SW,   1, 32'h008, LW,    6'b001010, 0, 2);
        add(0, 0, SW,   1, 32'h008, LW,    6'b001010, 0, 2);
        add(0, 0, SW,   1, 32'h008, LW,    6'b001010, 0, 2);
        add(0, 1, SW,   0, 32'h00C, SW,    6'b001010, 0, 2);
        add(0, 1, SW,   0, 32'h00C, SW,    6'b000010, 0, 2);
        add(0, 1, SW,   0, 32'h00C, SW,    6'b000110, 0, 2);
        add(0, 1, JMP,  1, 32'h00C, SW,    6'b000010, 0, 3);
        // j to word 0x40
        add(0, 1, JMP,  0, 32'h010, JMP,   6'b000010, 0, 3);
        add(0, 1, JMP,  0, 32'h010, JMP,   6'b000000, 0, 3);
        add(0, 1, ILL,  1, 32'h100, JMP,   6'b000000, 0, 4);
        // illegal opcode 3F
        add(0, 1, ILL,  0, 32'h104, ILL,   6'b000000, 0, 4);
        add(0, 1, ILL,  0, 32'h104, ILL,   6'b000000, 1, 4);
        add(0, 1, ILLF, 1, 32'h104, ILL,   6'b000000, 0, 4);
        // illegal R-type funct
        add(0, 1, ILLF, 0, 32'h108, ILLF,  6'b000000, 0, 4);
        add(0, 1, ILLF, 0, 32'h108, ILLF,  6'b000000, 1, 4);
        add(0, 1, ADDI, 1, 32'h108, ILLF,  6'b000000, 0, 4);
        // addi
        add(0, 1, ADDI, 0, 32'h10C, ADDI,  6'b000000, 0, 4);
        add(0, 1, ADDI, 0, 32'h10C, ADDI,  6'b000010, 0, 4);
        add(0, 1, ADDI, 0, 32'h10C, ADDI,  6'b000011, 0, 4);
        add(0, 1, ADD,  1, 32'h10C, ADDI,  6'b000010, 0, 5);
        // add aborted by reset in EXEC
        add(0, 1, ADD,  0, 32'h110, ADD,   6'b000010, 0, 5);
        add(0, 1, ADD,  0, 32'h110, ADD,   6'b100000, 0, 5);
        add(1, 1, ADD,  0, 32'h000, 32'h0, 6'b000000, 0, 0);
        add(0, 1, ADD,  1, 32'h000, 32'h0, 6'b000000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst0          = vecs[i].rst;
            if0.imemReady = vecs[i].rdy;
            if0.imemData  = vecs[i].data;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), pack0(), vecs[i].exp);
        end

        // ALU encodings for every supported R-type funct
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        alus   = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
        for (int k = 0; k < 6; k++) begin
            if0.imemReady = 1'b1;
            if0.imemData  = {26'b0000_0000_0010_0010_0001_1000_00, functs[k]};
            @(posedge clk);
            @(posedge clk);
            #1;
            check($sformatf("alu_funct%0h", functs[k]), {90'b0, rd0, alu0, ill0, 13'b0},
                  {90'b0, 1'b1, alus[k], 1'b0, 13'b0});
            @(posedge clk);
            @(posedge clk);
            #1;
        end
        check("retire_after_alu", {76'b0, retire0}, {76'b0, 32'd6});

        // Reset abort with PC wrap on the second instance
        check("dut1_reset", pack1(), mk(0, 32'hFFFF_FFFC, 32'h0, 6'b000000, 4'b0010, 0, 0));
        rst1          = 1'b0;
        if1.imemReady = 1'b1;
        if1.imemData  = ADD;
        @(posedge clk);
        #1;
        check("dut1_first_req", pack1(), mk(1, 32'hFFFF_FFFC, 32'h0, 6'b000000, 4'b0010, 0, 0));
        @(posedge clk);
        #1;
        check("dut1_pc_wrap", pack1(), mk(0, 32'h0, ADD, 6'b000000, 4'b0010, 0, 0));
        @(posedge clk);
        #1;
        check("dut1_exec", pack1(), mk(0, 32'h0, ADD, 6'b100000, 4'b0010, 0, 0));
        #1;
        rst1 = 1'b1;
        #1;
        check("dut1_async_abort", pack1(), mk(0, 32'hFFFF_FFFC, 32'h0, 6'b000000, 4'b0010, 0, 0));
        @(posedge clk);
        #1;
        check("dut1_no_regwrite", pack1(), mk(0, 32'hFFFF_FFFC, 32'h0, 6'b000000, 4'b0010, 0, 0));
        rst1 = 1'b0;
        @(posedge clk);
        #1;
        check("dut1_refetch", pack1(), mk(1, 32'hFFFF_FFFC, 32'h0, 6'b000000, 4'b0010, 0, 0));
        @(posedge clk);
        #1;
        check("dut1_second_addr", pack1(), mk(0, 32'h0, ADD, 6'b000000, 4'b0010, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
